// File: rtl/rs_pkg.sv
// Galois-field helpers shared by the Reed-Solomon decoder stages.
// Field elements are carried in 8 bits and masked to the active symbol width m.
package rs_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                        input int unsigned m, input logic [8:0] prim);
    logic [8:0] acc;
    logic [7:0] prod;
    logic [7:0] mask;
    mask = 8'((9'd1 << m) - 9'd1);
    prod = '0;
    acc  = {1'b0, a & mask};
    for (int unsigned i = 0; i < m; i++) begin
      if (b[i]) prod ^= acc[7:0];
      acc = acc << 1;
      if (acc[m]) acc ^= prim;
    end
    return prod & mask;
  endfunction

  function automatic logic [7:0] gf_pow(input int unsigned e, input int unsigned m,
                                        input logic [8:0] prim);
    logic [7:0] r;
    r = 8'd1;
    for (int unsigned i = 0; i < e; i++) r = gf_mul(r, 8'd2, m, prim);
    return r;
  endfunction

endpackage

// File: rtl/rs_syn_cell.sv
// One syndrome accumulator: Horner step s <= s*ROOT ^ sym.
// Exposes the next-state value so the top can latch results on the final step.
module rs_syn_cell
  import rs_pkg::*;
#(
  parameter int unsigned M    = 4,
  parameter logic [8:0]  PRIM = 9'h13,
  parameter logic [7:0]  ROOT = 8'h02
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         step,
  input  logic [M-1:0] sym,
  output logic [M-1:0] s_nxt
);

  logic [M-1:0] s;

  function automatic logic [M-1:0] mul_root(input logic [M-1:0] x);
    logic [7:0] t;
    t = '0;
    t[M-1:0] = x;
    t = gf_mul(t, ROOT, M, PRIM);
    return t[M-1:0];
  endfunction

  always_comb s_nxt = mul_root(s) ^ sym;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    s <= '0;
    else if (clr)  s <= '0;
    else if (step) s <= s_nxt;
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(N,K) syndrome calculator over GF(2^M): one symbol per clock, all 2T
// syndromes in parallel, error flag and saturating frame-error counter.
module rs_syndrome_calc
  import rs_pkg::*;
#(
  parameter int unsigned M     = 4,
  parameter int unsigned N     = 15,
  parameter int unsigned K     = 9,
  parameter logic [8:0]  PRIM  = 9'h13,
  parameter int unsigned FCR   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N*M-1:0]       datain,
  output logic                 busy,
  output logic                 rdy,
  output logic [(N-K)*M-1:0]   syndrome,
  output logic                 err,
  output logic [CNT_W-1:0]     err_cnt,
  input  logic                 cnt_clr
);

  localparam int unsigned    T2   = N - K;
  localparam int unsigned    CW   = $clog2(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t              state;
  logic [N*M-1:0]      sr;
  logic [CW-1:0]       cnt;
  logic [T2*M-1:0]     s_nxt;
  logic                clr;
  logic                step;
  logic                done;

  assign clr  = (state == ST_IDLE) && en;
  assign step = (state == ST_RUN);
  assign done = step && (cnt == LAST);
  assign busy = step;

  for (genvar g = 0; g < T2; g++) begin : g_cell
    rs_syn_cell #(
      .M    (M),
      .PRIM (PRIM),
      .ROOT (gf_pow(FCR + g, M, PRIM))
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .step  (step),
      .sym   (sr[N*M-1 -: M]),
      .s_nxt (s_nxt[g*M +: M])
    );
  end

  // Results are taken from the cells' next values so they land on the same edge as the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sr       <= '0;
      cnt      <= '0;
      rdy      <= 1'b0;
      syndrome <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      rdy <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            sr    <= datain;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sr  <= sr << M;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= ST_IDLE;
            rdy      <= 1'b1;
            syndrome <= s_nxt;
            err      <= |s_nxt;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (cnt_clr)
        err_cnt <= '0;
      else if (done && (|s_nxt) && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc: default RS(15,9) instance plus an
// RS(255,239) instance with a 4-bit error counter for saturation and clear.
module tb_rs_syndrome_calc;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          a_en, a_busy, a_rdy, a_err, a_clr;
  logic [59:0]   a_datain;
  logic [23:0]   a_syn;
  logic [15:0]   a_cnt;

  logic          b_en, b_busy, b_rdy, b_err, b_clr;
  logic [2039:0] b_datain;
  logic [127:0]  b_syn;
  logic [3:0]    b_cnt;

  rs_syndrome_calc u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .datain(a_datain), .busy(a_busy),
    .rdy(a_rdy), .syndrome(a_syn), .err(a_err), .err_cnt(a_cnt), .cnt_clr(a_clr)
  );

  rs_syndrome_calc #(.M(8), .N(255), .K(239), .PRIM(9'h11D), .FCR(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .datain(b_datain), .busy(b_busy),
    .rdy(b_rdy), .syndrome(b_syn), .err(b_err), .err_cnt(b_cnt), .cnt_clr(b_clr)
  );

  int n_chk = 0;
  int n_fail = 0;
  int exp4[0:14];
  int log4[0:15];
  int exp8[0:254];
  int log8[0:255];
  int g[0:6];
  int c[0:14];

  logic [59:0]   da;
  logic [2039:0] db;
  logic [127:0]  sb;
  int lat, ecnt, pos, ev, seen, mv;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int gmul(input int a, input int b, input bit wide);
    if (a == 0 || b == 0) return 0;
    if (wide) return exp8[(log8[a] + log8[b]) % 255];
    return exp4[(log4[a] + log4[b]) % 15];
  endfunction

  // Direct evaluation: S_i = sum_j r_j * alpha^((FCR+i)*j)
  function automatic logic [23:0] syn_a(input logic [59:0] d);
    logic [23:0] res;
    int s;
    res = '0;
    for (int i = 0; i < 6; i++) begin
      s = 0;
      for (int j = 0; j < 15; j++) s ^= gmul(int'(d[j*4 +: 4]), exp4[((1 + i) * j) % 15], 1'b0);
      res[i*4 +: 4] = 4'(s);
    end
    return res;
  endfunction

  function automatic logic [127:0] syn_b(input logic [2039:0] d);
    logic [127:0] res;
    int s;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      s = 0;
      for (int j = 0; j < 255; j++) s ^= gmul(int'(d[j*8 +: 8]), exp8[(i * j) % 255], 1'b1);
      res[i*8 +: 8] = 8'(s);
    end
    return res;
  endfunction

  task automatic start_a(input logic [59:0] d);
    @(negedge clk);
    a_datain = d;
    a_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_en = 1'b0;
    a_datain = ~d;
  endtask

  task automatic start_b(input logic [2039:0] d);
    @(negedge clk);
    b_datain = d;
    b_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_en = 1'b0;
    b_datain = ~d;
  endtask

  // Counts edges from the en-sampling edge up to the one that raises rdy.
  task automatic wait_rdy(input bit sel_b, input bit pulse, output int n);
    n = 1;
    for (int k = 0; k < 300; k++) begin
      if (pulse) a_en = (n == 3 || n == 5);
      @(posedge clk);
      n++;
      @(negedge clk);
      if (sel_b ? b_rdy : a_rdy) break;
    end
    a_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 1'b0; a_clr = 1'b0; a_datain = '0;
    b_en = 1'b0; b_clr = 1'b0; b_datain = '0;

    exp4[0] = 1;
    for (int k = 1; k < 15; k++) begin
      exp4[k] = exp4[k-1] << 1;
      if ((exp4[k] & 16) != 0) exp4[k] ^= 'h13;
    end
    log4[0] = 0;
    for (int k = 0; k < 15; k++) log4[exp4[k]] = k;
    exp8[0] = 1;
    for (int k = 1; k < 255; k++) begin
      exp8[k] = exp8[k-1] << 1;
      if ((exp8[k] & 256) != 0) exp8[k] ^= 'h11D;
    end
    log8[0] = 0;
    for (int k = 0; k < 255; k++) log8[exp8[k]] = k;

    #1;
    check("reset_busy", a_busy, 0);
    check("reset_rdy", a_rdy, 0);
    check("reset_syn", a_syn, 0);
    check("reset_err", a_err, 0);
    check("reset_cnt", a_cnt, 0);
    check("reset_b_busy", b_busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // all-zero codeword
    start_a(60'h0);
    check("zero_busy", a_busy, 1);
    wait_rdy(1'b0, 1'b0, lat);
    check("zero_latency", lat, 16);
    check("zero_syn", a_syn, 24'h0);
    check("zero_err", a_err, 0);
    check("zero_cnt", a_cnt, 0);
    @(negedge clk);
    check("zero_rdy_pulse", a_rdy, 0);
    check("zero_idle", a_busy, 0);

    // error value 1 at x^0
    start_a(60'h1);
    wait_rdy(1'b0, 1'b0, lat);
    check("x0_latency", lat, 16);
    check("x0_syn", a_syn, 24'h111111);
    check("x0_err", a_err, 1);
    check("x0_cnt", a_cnt, 1);

    // error value 1 at x^1: alpha^1..alpha^6
    start_a(60'h10);
    wait_rdy(1'b0, 1'b0, lat);
    check("x1_syn", a_syn, 24'hC63842);
    check("x1_err", a_err, 1);
    check("x1_cnt", a_cnt, 2);

    // back-to-back: en on the rdy cycle
    a_datain = 60'h100;
    a_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_en = 1'b0;
    a_datain = '1;
    check("b2b_busy", a_busy, 1);
    check("b2b_rdy_low", a_rdy, 0);
    check("b2b_syn_hold", a_syn, 24'hC63842);
    wait_rdy(1'b0, 1'b0, lat);
    check("b2b_latency", lat, 16);
    check("b2b_syn", a_syn, syn_a(60'h100));
    check("b2b_cnt", a_cnt, 3);

    // valid codeword: random combination of shifted generator polynomials
    g[0] = 1;
    for (int k = 1; k < 7; k++) g[k] = 0;
    for (int i = 1; i <= 6; i++)
      for (int k = 6; k >= 0; k--) g[k] = (k > 0 ? g[k-1] : 0) ^ gmul(g[k], exp4[i], 1'b0);
    for (int j = 0; j < 15; j++) c[j] = 0;
    for (int k = 0; k < 9; k++) begin
      mv = $urandom_range(1, 15);
      for (int t = 0; t < 7; t++) c[k+t] ^= gmul(mv, g[t], 1'b0);
    end
    da = '0;
    for (int j = 0; j < 15; j++) da[j*4 +: 4] = 4'(c[j]);
    start_a(da);
    wait_rdy(1'b0, 1'b0, lat);
    check("cw_syn", a_syn, 24'h0);
    check("cw_err", a_err, 0);
    check("cw_cnt", a_cnt, 3);

    pos = $urandom_range(0, 14);
    ev = $urandom_range(1, 15);
    da[pos*4 +: 4] = da[pos*4 +: 4] ^ 4'(ev);
    start_a(da);
    wait_rdy(1'b0, 1'b0, lat);
    check("cw_flip_syn", a_syn, syn_a(da));
    check("cw_flip_err", a_err, 1);
    check("cw_flip_cnt", a_cnt, 4);

    // en pulses while busy are ignored
    start_a(60'h10);
    wait_rdy(1'b0, 1'b1, lat);
    check("busy_en_latency", lat, 16);
    check("busy_en_syn", a_syn, 24'hC63842);
    check("busy_en_cnt", a_cnt, 5);

    // reset in the middle of a frame
    start_a(60'h1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", a_busy, 0);
    check("midrst_rdy", a_rdy, 0);
    check("midrst_syn", a_syn, 0);
    check("midrst_err", a_err, 0);
    check("midrst_cnt", a_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_rdy || a_busy) seen++;
    end
    check("midrst_no_rdy", seen, 0);
    start_a(60'h10);
    wait_rdy(1'b0, 1'b0, lat);
    check("postrst_latency", lat, 16);
    check("postrst_syn", a_syn, 24'hC63842);
    check("postrst_cnt", a_cnt, 1);

    // wide field: single error
    db = '0;
    db[5*8 +: 8] = 8'h37;
    start_b(db);
    wait_rdy(1'b1, 1'b0, lat);
    check("b_single_latency", lat, 256);
    check("b_single_syn", b_syn, syn_b(db));
    check("b_single_err", b_err, 1);
    check("b_single_cnt", b_cnt, 1);
    ecnt = 1;

    // random frames drive the 4-bit counter into saturation
    for (int f = 0; f < 20; f++) begin
      for (int j = 0; j < 255; j++) db[j*8 +: 8] = 8'($urandom);
      sb = syn_b(db);
      if (sb != 0 && ecnt < 15) ecnt++;
      start_b(db);
      wait_rdy(1'b1, 1'b0, lat);
      check("b_rand_syn", b_syn, sb);
      check("b_rand_err", b_err, (sb != 0));
    end
    check("b_sat_cnt", b_cnt, ecnt);
    check("b_sat_value", b_cnt, 15);

    // clear wins over an increment on the same edge
    for (int j = 0; j < 255; j++) db[j*8 +: 8] = 8'($urandom);
    sb = syn_b(db);
    start_b(db);
    b_clr = 1'b1;
    wait_rdy(1'b1, 1'b0, lat);
    check("b_clr_err", b_err, (sb != 0));
    check("b_clr_cnt", b_cnt, 0);
    b_clr = 1'b0;
    db = '0;
    db[200*8 +: 8] = 8'hA5;
    start_b(db);
    wait_rdy(1'b1, 1'b0, lat);
    check("b_after_clr_syn", b_syn, syn_b(db));
    check("b_after_clr_cnt", b_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
